// File: rtl/pipeline_pkg.sv
// Shared types for the Memory/Writeback end of the pipeline: stage control
// bundles, the data-memory handshake state and default datapath widths.
package pipeline_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 4;

   typedef struct packed {
      logic PCSrc;
      logic RegWrite;
      logic MemtoReg;
      logic MemWrite;
   } ctrl_m_t;

   typedef struct packed {
      logic PCSrc;
      logic RegWrite;
      logic MemtoReg;
   } ctrl_w_t;

   typedef enum logic {IDLE, WAIT} mem_state_t;

   // The store flag has no meaning past Memory, so it is dropped here.
   function automatic ctrl_w_t to_ctrl_w(input ctrl_m_t c);
      ctrl_w_t w;
      w.PCSrc    = c.PCSrc;
      w.RegWrite = c.RegWrite;
      w.MemtoReg = c.MemtoReg;
      return w;
   endfunction

endpackage

// File: rtl/stage_reg.sv
// Pipeline register: async reset, hold when en=0, synchronous clr inserts a bubble.
// clr wins over en so a stalled producer never leaks a stale copy downstream.
module stage_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     q <= '0;
      else if (clr)  q <= '0;
      else if (en)   q <= d;
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory and Writeback stages: data-memory req/ack handshake with upstream stall,
// then the register-file / PC write port. Optional ack timeout: MEM_TIMEOUT_EN.
module mem_wb_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int REG_AW  = DEF_REG_AW,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCSrcE,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              MemWriteE,
   input  logic [REG_AW-1:0] RdE,
   input  logic [DATA_W-1:0] ALUResultE,
   input  logic [DATA_W-1:0] WriteDataE,
   output logic              StallM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              PCSrcW,
   output logic              RegWriteW,
   output logic [REG_AW-1:0] RdW,
   output logic [DATA_W-1:0] ResultW,
   output logic              MemErrW
);

   localparam int MW = $bits(ctrl_m_t) + REG_AW + 2 * DATA_W;
   localparam int WW = $bits(ctrl_w_t) + REG_AW + 2 * DATA_W;

   ctrl_m_t           ctrl_e, ctrl_m;
   ctrl_w_t           ctrl_w;
   logic [REG_AW-1:0] rd_m;
   logic [DATA_W-1:0] alu_out_m, write_data_m, read_data_m;
   logic [DATA_W-1:0] alu_out_w, read_data_w;
   logic              memop, ack_ok, force_done;
   mem_state_t        state;

   assign ctrl_e = '{PCSrc: PCSrcE, RegWrite: RegWriteE, MemtoReg: MemtoRegE, MemWrite: MemWriteE};

   stage_reg #(.W(MW)) u_m_reg (
      .clk   (clk),
      .reset (reset),
      .en    (~StallM),
      .clr   (1'b0),
      .d     ({ctrl_e, RdE, ALUResultE, WriteDataE}),
      .q     ({ctrl_m, rd_m, alu_out_m, write_data_m})
   );

   assign memop     = ctrl_m.MemWrite | ctrl_m.MemtoReg;
   assign mem_req   = memop & ~force_done;
   assign mem_we    = ctrl_m.MemWrite;
   assign mem_addr  = alu_out_m;
   assign mem_wdata = write_data_m;
   // A stray ack with no request outstanding must not release anything.
   assign ack_ok    = mem_ack & mem_req;
   assign StallM    = memop & ~ack_ok & ~force_done;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] wait_cnt;

   // wait_cnt counts stalled cycles of the current access, so the access is
   // abandoned after TIMEOUT-1 of them.
   assign force_done = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           MemErrW <= 1'b0;
      else if (force_done) MemErrW <= 1'b1;
   end
`else
   logic unused_cfg;
   assign unused_cfg = TIMEOUT[0];
   assign force_done = 1'b0;
   assign MemErrW    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
`ifdef MEM_TIMEOUT_EN
         wait_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (memop & ~ack_ok) begin
                  state <= WAIT;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt <= CW'(1);
`endif
               end else begin
`ifdef MEM_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
            WAIT: begin
               if (ack_ok | force_done) begin
                  state <= IDLE;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else begin
`ifdef MEM_TIMEOUT_EN
                  wait_cnt <= wait_cnt + CW'(1);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Abandoned loads write back zero instead of whatever is on the bus.
   assign read_data_m = (ctrl_m.MemtoReg & ack_ok) ? mem_rdata : '0;

   stage_reg #(.W(WW)) u_w_reg (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .clr   (StallM),
      .d     ({to_ctrl_w(ctrl_m), rd_m, alu_out_m, read_data_m}),
      .q     ({ctrl_w, RdW, alu_out_w, read_data_w})
   );

   assign PCSrcW    = ctrl_w.PCSrc;
   assign RegWriteW = ctrl_w.RegWrite;
   assign ResultW   = ctrl_w.MemtoReg ? read_data_w : alu_out_w;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized
// program checked against an in-order writeback model and a latency-driven memory.
module tb_mem_wb_stage;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
   logic [AW-1:0] RdE;
   logic [DW-1:0] ALUResultE, WriteDataE;
   logic          StallM, mem_req, mem_we, mem_ack;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
   logic          PCSrcW, RegWriteW, MemErrW;
   logic [AW-1:0] RdW;
   logic [DW-1:0] ResultW;

   always #5 clk = ~clk;

   mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .MemErrW(MemErrW)
   );

   typedef struct {
      bit        pcsrc, regwrite, memtoreg, memwrite;
      bit [3:0]  rd;
      bit [31:0] alu, wd;
   } instr_t;

   typedef struct {
      bit        pcsrc, regwrite;
      bit [3:0]  rd;
      bit [31:0] res;
      int        cyc;
   } wb_t;

   int checks = 0, errors = 0;
   int cyc = 0;
   instr_t    nop_i;
   instr_t    prog[$];
   int        lat_q[$];
   bit [31:0] rdata_q[$];
   wb_t       obs[$];
   int        cap_cyc[$];
   bit [31:0] load_data[$], req_addr[$], req_wd[$];
   bit        req_we[$];
   int        stall_cycles, req_count, unstable;
   bit        timed_out;

   function automatic instr_t mk(bit pc, bit rw, bit m2r, bit mw, bit [3:0] rd, bit [31:0] alu, bit [31:0] wd);
      instr_t i;
      i.pcsrc = pc; i.regwrite = rw; i.memtoreg = m2r; i.memwrite = mw;
      i.rd = rd; i.alu = alu; i.wd = wd;
      return i;
   endfunction

   task automatic drive_e(input instr_t i);
      PCSrcE = i.pcsrc; RegWriteE = i.regwrite; MemtoRegE = i.memtoreg; MemWriteE = i.memwrite;
      RdE = i.rd; ALUResultE = i.alu; WriteDataE = i.wd;
   endtask

   // In-order architectural model: every instruction that writes a register or
   // the PC retires exactly once, loads returning the data the memory handed out.
   function automatic void model(output wb_t q[$]);
      int li = 0;
      q.delete();
      foreach (prog[k]) begin
         wb_t w;
         w.pcsrc = prog[k].pcsrc; w.regwrite = prog[k].regwrite; w.rd = prog[k].rd; w.cyc = 0;
         if (prog[k].memtoreg) begin
            w.res = (li < load_data.size()) ? load_data[li] : 32'h0;
            li++;
         end else w.res = prog[k].alu;
         if (w.pcsrc || w.regwrite) q.push_back(w);
      end
   endfunction

   // Feeds prog through E (honouring StallM), plays the memory, records W traffic.
   task automatic run_prog(input int budget);
      int idx = 0, tail = 0, waited = 0, lat = 0, n = 0;
      bit in_burst = 1'b0, stall_pre;
      obs.delete(); cap_cyc.delete(); load_data.delete();
      req_addr.delete(); req_wd.delete(); req_we.delete();
      stall_cycles = 0; req_count = 0; unstable = 0; timed_out = 1'b0;
      if (prog.size() > 0) drive_e(prog[0]); else drive_e(nop_i);
      while (idx < prog.size() || tail < 6) begin
         if (n++ >= budget) begin timed_out = 1'b1; break; end
         @(negedge clk);
         if (mem_req) begin
            if (!in_burst) begin
               in_burst = 1'b1; waited = 0; req_count++;
               lat = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(0, 3));
               req_addr.push_back(mem_addr); req_wd.push_back(mem_wdata); req_we.push_back(mem_we);
            end else if (mem_addr !== req_addr[$] || mem_wdata !== req_wd[$] || mem_we !== req_we[$])
               unstable++;
            if (waited == lat) begin
               mem_ack = 1'b1;
               mem_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
               if (!mem_we) load_data.push_back(mem_rdata);
               in_burst = 1'b0;
            end else begin
               mem_ack = 1'b0; mem_rdata = $urandom; waited++;
            end
         end else begin
            in_burst = 1'b0;
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
         #1 stall_pre = StallM;
         if (StallM) stall_cycles++;
         @(posedge clk); #1;
         cyc++;
         if (!stall_pre && idx < prog.size()) begin cap_cyc.push_back(cyc); idx++; end
         else if (!stall_pre) tail++;
         if (idx < prog.size()) drive_e(prog[idx]); else drive_e(nop_i);
         if (RegWriteW || PCSrcW) begin
            wb_t w;
            w.pcsrc = PCSrcW; w.regwrite = RegWriteW; w.rd = RdW; w.res = ResultW; w.cyc = cyc;
            obs.push_back(w);
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      drive_e(mk(1, 1, 1, 1, 4'hF, 32'h1234, 32'h5678));
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallM); end
      checks++; if ({PCSrcW, RegWriteW} !== 2'b00) begin errors++; $display("FAIL reset_wctrl: got %b want 00", {PCSrcW, RegWriteW}); end
      checks++; if (ResultW !== 32'h0 || RdW !== 4'h0) begin errors++; $display("FAIL reset_wdata: got %h/%h want 0/0", ResultW, RdW); end
      checks++; if (mem_addr !== 32'h0 || MemErrW !== 1'b0) begin errors++; $display("FAIL reset_misc: addr %h err %b want 0", mem_addr, MemErrW); end
      drive_e(nop_i); mem_ack = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      prog = '{mk(0, 1, 0, 0, 4'd3, 32'h11, 32'h0)};
      run_prog(200);
      checks++; if (timed_out || obs.size() != 1) begin errors++; $display("FAIL alu_count: got %0d wb want 1 (to=%b)", obs.size(), timed_out); end
      else begin
         checks++; if (obs[0].rd !== 4'd3 || obs[0].res !== 32'h11) begin errors++; $display("FAIL alu_wb: got R%0d=%h want R3=11", obs[0].rd, obs[0].res); end
         checks++; if (obs[0].cyc != cap_cyc[0] + 1) begin errors++; $display("FAIL alu_latency: got W at %0d want %0d", obs[0].cyc, cap_cyc[0] + 1); end
      end
      checks++; if (req_count != 0) begin errors++; $display("FAIL alu_no_req: got %0d requests want 0", req_count); end
   endtask

   task automatic test_load_zero_wait();
      prog = '{mk(0, 1, 1, 0, 4'd4, 32'h40, 32'h0)}; lat_q = '{0}; rdata_q = '{32'hDEAD};
      run_prog(200);
      checks++; if (stall_cycles != 0) begin errors++; $display("FAIL ld0_stall: got %0d stall cycles want 0", stall_cycles); end
      checks++; if (timed_out || obs.size() != 1) begin errors++; $display("FAIL ld0_count: got %0d wb want 1", obs.size()); end
      else begin
         checks++; if (obs[0].res !== 32'hDEAD || obs[0].rd !== 4'd4) begin errors++; $display("FAIL ld0_data: got R%0d=%h want R4=dead", obs[0].rd, obs[0].res); end
         checks++; if (obs[0].cyc != cap_cyc[0] + 1) begin errors++; $display("FAIL ld0_latency: got %0d want %0d", obs[0].cyc, cap_cyc[0] + 1); end
      end
      checks++; if (req_count != 1 || req_addr.size() < 1 || req_addr[0] !== 32'h40) begin errors++; $display("FAIL ld0_req: got %0d requests want 1 at 40", req_count); end
   endtask

   task automatic test_store_wait();
      prog = '{mk(0, 0, 0, 1, 4'd0, 32'h80, 32'hCAFE), mk(0, 1, 0, 0, 4'd5, 32'h77, 32'h0)};
      lat_q = '{3};
      run_prog(200);
      checks++; if (stall_cycles != 3) begin errors++; $display("FAIL st_stall: got %0d stall cycles want 3", stall_cycles); end
      checks++; if (req_count != 1 || unstable != 0) begin errors++; $display("FAIL st_burst: got %0d bursts %0d unstable want 1/0", req_count, unstable); end
      if (req_addr.size() > 0) begin
         checks++; if (req_addr[0] !== 32'h80 || req_wd[0] !== 32'hCAFE || req_we[0] !== 1'b1) begin errors++; $display("FAIL st_bus: got a=%h d=%h we=%b want 80/cafe/1", req_addr[0], req_wd[0], req_we[0]); end
      end
      checks++; if (timed_out || obs.size() != 1) begin errors++; $display("FAIL st_wb_count: got %0d wb want 1", obs.size()); end
      else begin
         checks++; if (obs[0].rd !== 4'd5 || obs[0].cyc != cap_cyc[1] + 1) begin errors++; $display("FAIL st_follow: got R%0d at %0d want R5 at %0d", obs[0].rd, obs[0].cyc, cap_cyc[1] + 1); end
      end
   endtask

   task automatic test_back_to_back();
      prog = '{mk(0, 1, 1, 0, 4'd1, 32'h10, 32'h0), mk(0, 1, 1, 0, 4'd2, 32'h14, 32'h0)};
      lat_q = '{1, 1};
      run_prog(200);
      checks++; if (req_count != 2 || stall_cycles != 2) begin errors++; $display("FAIL b2b_req: got %0d req %0d stall want 2/2", req_count, stall_cycles); end
      if (req_addr.size() == 2) begin
         checks++; if (req_addr[0] !== 32'h10 || req_addr[1] !== 32'h14) begin errors++; $display("FAIL b2b_addr: got %h,%h want 10,14", req_addr[0], req_addr[1]); end
      end
      checks++; if (timed_out || obs.size() != 2 || load_data.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d wb want 2", obs.size()); end
      else begin
         checks++; if (obs[0].rd !== 4'd1 || obs[0].res !== load_data[0]) begin errors++; $display("FAIL b2b_first: got R%0d=%h want R1=%h", obs[0].rd, obs[0].res, load_data[0]); end
         checks++; if (obs[1].rd !== 4'd2 || obs[1].res !== load_data[1]) begin errors++; $display("FAIL b2b_second: got R%0d=%h want R2=%h", obs[1].rd, obs[1].res, load_data[1]); end
      end
   endtask

   task automatic test_random();
      wb_t exp_q[$];
      int memops = 0;
      prog.delete(); lat_q.delete(); rdata_q.delete();
      for (int k = 0; k < 60; k++) begin
         int kind = int'($urandom_range(0, 3));
         bit [3:0] rd = 4'($urandom);
         case (kind)
            0: prog.push_back(mk(0, 1'($urandom_range(0, 3) != 0), 0, 0, rd, $urandom, $urandom));
            1: prog.push_back(mk(0, 1, 1, 0, rd, $urandom, $urandom));
            2: prog.push_back(mk(0, 0, 0, 1, rd, $urandom, $urandom));
            default: prog.push_back(mk(1, 1'($urandom_range(0, 1)), 0, 0, rd, $urandom, $urandom));
         endcase
         if (kind == 1 || kind == 2) memops++;
      end
      run_prog(2000);
      model(exp_q);
      checks++; if (timed_out) begin errors++; $display("FAIL rnd_budget: ran out of cycles"); end
      checks++; if (req_count != memops || unstable != 0) begin errors++; $display("FAIL rnd_req: got %0d req %0d unstable want %0d/0", req_count, unstable, memops); end
      checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d wb want %0d", obs.size(), exp_q.size()); end
      for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
         checks++;
         if (obs[k].pcsrc !== exp_q[k].pcsrc || obs[k].regwrite !== exp_q[k].regwrite ||
             obs[k].rd !== exp_q[k].rd || obs[k].res !== exp_q[k].res) begin
            errors++;
            $display("FAIL rnd_wb[%0d]: got pc=%b rw=%b R%0d=%h want pc=%b rw=%b R%0d=%h", k,
                     obs[k].pcsrc, obs[k].regwrite, obs[k].rd, obs[k].res,
                     exp_q[k].pcsrc, exp_q[k].regwrite, exp_q[k].rd, exp_q[k].res);
         end
      end
   endtask

   task automatic test_reset_wait();
      drive_e(mk(0, 1, 1, 0, 4'd9, 32'h44, 32'h0)); mem_ack = 1'b0;
      @(posedge clk); #1;
      drive_e(nop_i);
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || StallM !== 1'b1) begin errors++; $display("FAIL rw_pending: got req=%b stall=%b want 1/1", mem_req, StallM); end
      @(posedge clk); #1;
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0 || StallM !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL rw_async: got req=%b stall=%b rw=%b want 000", mem_req, StallM, RegWriteW); end
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      prog = '{mk(0, 1, 1, 0, 4'd6, 32'h48, 32'h0)}; lat_q = '{0}; rdata_q = '{32'hBEEF};
      run_prog(200);
      checks++; if (stall_cycles != 0 || req_count != 1) begin errors++; $display("FAIL rw_idle_after: got stall=%0d req=%0d want 0/1", stall_cycles, req_count); end
      checks++; if (obs.size() != 1 || obs[0].res !== 32'hBEEF) begin errors++; $display("FAIL rw_resume: got %0d wb want one R6=beef", obs.size()); end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      prog = '{mk(0, 1, 1, 0, 4'd7, 32'h100, 32'h0), mk(0, 1, 0, 0, 4'd8, 32'h55, 32'h0)};
      lat_q = '{1000};
      run_prog(200);
      checks++; if (stall_cycles != TO - 1) begin errors++; $display("FAIL to_stall: got %0d stall cycles want %0d", stall_cycles, TO - 1); end
      checks++; if (obs.size() != 2) begin errors++; $display("FAIL to_count: got %0d wb want 2", obs.size()); end
      else begin
         checks++; if (obs[0].rd !== 4'd7 || obs[0].res !== 32'h0) begin errors++; $display("FAIL to_data: got R%0d=%h want R7=0", obs[0].rd, obs[0].res); end
      end
      checks++; if (MemErrW !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", MemErrW); end
      prog = '{mk(0, 1, 0, 0, 4'd2, 32'h9, 32'h0)}; lat_q.delete();
      run_prog(200);
      checks++; if (MemErrW !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", MemErrW); end
   endtask
`else
   task automatic test_memerr_off();
      prog = '{mk(0, 1, 1, 0, 4'd7, 32'h100, 32'h0)}; lat_q = '{20};
      run_prog(200);
      checks++; if (stall_cycles != 20 || MemErrW !== 1'b0) begin errors++; $display("FAIL noto_wait: got stall=%0d err=%b want 20/0", stall_cycles, MemErrW); end
   endtask
`endif

   initial begin
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
      drive_e(nop_i);
      test_reset();
      test_alu();
      test_load_zero_wait();
      test_store_wait();
      test_back_to_back();
      test_random();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`else
      test_memerr_off();
`endif
      test_reset_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
